adder_arbiter: RTL and testbench

//  Shares one multi-cycle 513-bit adder/subtractor between NUM_REQ requesters
//  (e.g. Montgomery loop datapath, final-subtraction unit). Round-robin arbitration.

---
 rtl/adder_arbiter_if.sv | 20 ++
 rtl/adder_arbiter.sv | 147 ++++++++++++++
 tb/tb_adder_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Bus between the arbiter and the shared multi-cycle 513-bit adder/subtractor.
// The arbiter uses the master view; the adder uses the slave view.
interface adder_arbiter_if;
  logic         add_start;
  logic         add_subtract;
  logic [512:0] add_in_a;
  logic [512:0] add_in_b;
  logic [513:0] add_result;
  logic         add_done;

  modport master (
    output add_start, add_subtract, add_in_a, add_in_b,
    input  add_result, add_done
  );

  modport slave (
    input  add_start, add_subtract, add_in_a, add_in_b,
    output add_result, add_done
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one multi-cycle 513-bit adder between NUM_REQ requesters.
// Latches the winner's operands, pulses start, waits for done (with watchdog), returns result.
module adder_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int MAX_WAIT = 255
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0]       req_sub_i,
  input  logic [NUM_REQ*513-1:0]   req_a_i,
  input  logic [NUM_REQ*513-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [513:0]             rsp_result_o,
  output logic                     busy_o,
  output logic                     timeout_err_o,
  input  logic                     err_clr_i,
  adder_arbiter_if.master          add_bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [512:0]   a_q, a_d;
  logic [512:0]   b_q, b_d;
  logic           sub_q, sub_d;
  logic [513:0]   result_q, result_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic           winFound;
  logic [IW-1:0]  winIdx;
  logic [IW-1:0]  cand;
  logic [NUM_REQ-1:0] idxOneHot;
  logic           driveAdder;

  // Search starts just after the last winner, so each requester gets a turn.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!winFound && req_i[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    err_d    = err_clr_i ? 1'b0 : err_q;
    case (state_q)
      S_IDLE: begin
        if (winFound) begin
          state_d = S_ISSUE;
          ptr_d   = winIdx;
          idx_d   = winIdx;
          a_d     = req_a_i[int'(winIdx)*513 +: 513];
          b_d     = req_b_i[int'(winIdx)*513 +: 513];
          sub_d   = req_sub_i[winIdx];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle still produces a response.
        if (add_bus.add_done) begin
          result_d = add_bus.add_result;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(MAX_WAIT - 1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      ptr_q    <= IW'(NUM_REQ - 1);
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    idxOneHot        = '0;
    idxOneHot[idx_q] = 1'b1;
  end

  assign driveAdder = (state_q == S_ISSUE) || (state_q == S_WAIT);

  assign grant_o       = (state_q == S_ISSUE) ? idxOneHot : '0;
  assign rsp_valid_o   = (state_q == S_RESP)  ? idxOneHot : '0;
  assign rsp_result_o  = result_q;
  assign busy_o        = (state_q != S_IDLE);
  assign timeout_err_o = err_q;

  assign add_bus.add_start    = (state_q == S_ISSUE);
  assign add_bus.add_subtract = driveAdder ? sub_q : 1'b0;
  assign add_bus.add_in_a     = driveAdder ? a_q : '0;
  assign add_bus.add_in_b     = driveAdder ? b_q : '0;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: two requesters, a small adder model with a
// fixed latency that can be stubbed to never finish, and hand-computed results.
module tb_adder_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int MAX_WAIT = 16;
  localparam int ADD_LAT  = 4;

  logic           clk;
  logic           resetn;
  logic [1:0]     req;
  logic [1:0]     reqSub;
  logic [1025:0]  reqA;
  logic [1025:0]  reqB;
  logic [1:0]     grant;
  logic [1:0]     rspValid;
  logic [513:0]   rspResult;
  logic           busy;
  logic           timeoutErr;
  logic           errClr;

  logic           stubMode;
  logic           manualDone;
  int             remain;
  logic [513:0]   modelRes;

  int             testsRun;
  int             testsFailed;

  adder_arbiter_if addBus();

  adder_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_i         (req),
    .req_sub_i     (reqSub),
    .req_a_i       (reqA),
    .req_b_i       (reqB),
    .grant_o       (grant),
    .rsp_valid_o   (rspValid),
    .rsp_result_o  (rspResult),
    .busy_o        (busy),
    .timeout_err_o (timeoutErr),
    .err_clr_i     (errClr),
    .add_bus       (addBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: done pulses ADD_LAT edges after the edge that ends the start cycle.
  always @(posedge clk) begin
    if (!resetn) begin
      remain            <= 0;
      addBus.add_done   <= 1'b0;
      addBus.add_result <= '0;
    end else begin
      addBus.add_done <= manualDone;
      if (remain > 0) begin
        remain <= remain - 1;
        if (remain == 1) begin
          addBus.add_done   <= 1'b1;
          addBus.add_result <= modelRes;
        end
      end else if (addBus.add_start && !stubMode) begin
        remain   <= ADD_LAT;
        modelRes <= addBus.add_subtract ? ({1'b0, addBus.add_in_a} - {1'b0, addBus.add_in_b})
                                        : ({1'b0, addBus.add_in_a} + {1'b0, addBus.add_in_b});
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [513:0] observed, input logic [513:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] reqMask, input logic [1:0] subMask,
                               input logic [512:0] a0, input logic [512:0] b0,
                               input logic [512:0] a1, input logic [512:0] b1);
    reqSub = subMask;
    reqA   = {a1, a0};
    reqB   = {b1, b0};
    req    = reqMask;
  endtask

  task automatic waitGrant(input string tag, input logic [1:0] expGrant);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (grant != 2'b00) found = 1'b1;
    end
    checkOutput({tag, " grant seen"}, found, 1);
    checkOutput({tag, " grant"}, grant, expGrant);
    checkOutput({tag, " start"}, addBus.add_start, 1);
  endtask

  // Returns at the negedge inside the response cycle.
  task automatic waitResp(input string tag, input logic expSub);
    logic found;
    logic prevDone;
    int   extraGrants;
    int   subBad;
    found = 1'b0;
    prevDone = 1'b0;
    extraGrants = 0;
    subBad = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (rspValid != 2'b00) begin
        found = 1'b1;
      end else begin
        if (grant != 2'b00) extraGrants++;
        if (addBus.add_subtract !== expSub) subBad++;
        prevDone = addBus.add_done;
      end
    end
    checkOutput({tag, " resp seen"}, found, 1);
    checkOutput({tag, " done before resp"}, prevDone, 1);
    checkOutput({tag, " extra grants"}, extraGrants, 0);
    checkOutput({tag, " subtract stable"}, subBad, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got running expected finished");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    logic [1:0]   expSeq [4];
    logic [512:0] allOnes;
    logic [513:0] expSum;
    int           busyCnt;
    logic         errEarly;
    logic         validSeen;

    testsRun    = 0;
    testsFailed = 0;
    resetn      = 1'b0;
    errClr      = 1'b0;
    stubMode    = 1'b0;
    manualDone  = 1'b0;
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (3) @(negedge clk);

    checkOutput("reset busy", busy, 0);
    checkOutput("reset grant", grant, 0);
    checkOutput("reset valid", rspValid, 0);
    checkOutput("reset result", rspResult, 0);
    checkOutput("reset err", timeoutErr, 0);
    checkOutput("reset start", addBus.add_start, 0);
    checkOutput("reset in_a", addBus.add_in_a, 0);
    checkOutput("reset sub", addBus.add_subtract, 0);
    resetn = 1'b1;

    // Test 1: requester 0 adds 5 + 3
    applyStimulus(2'b01, 2'b00, 513'd5, 513'd3, '0, '0);
    waitGrant("t1", 2'b01);
    checkOutput("t1 in_a", addBus.add_in_a, 5);
    checkOutput("t1 in_b", addBus.add_in_b, 3);
    req = 2'b00;
    waitResp("t1", 1'b0);
    checkOutput("t1 valid", rspValid, 2'b01);
    checkOutput("t1 result", rspResult, 8);
    @(negedge clk);
    checkOutput("t1 valid one cycle", rspValid, 0);
    checkOutput("t1 idle", busy, 0);
    checkOutput("t1 result held", rspResult, 8);
    checkOutput("t1 in_a idle", addBus.add_in_a, 0);

    // Stray done while idle must be ignored
    manualDone = 1'b1;
    @(negedge clk);
    manualDone = 1'b0;
    @(negedge clk);
    checkOutput("stray done busy", busy, 0);
    checkOutput("stray done valid", rspValid, 0);
    checkOutput("stray done result", rspResult, 8);

    // Test 2: requester 1 subtracts 10 - 3
    applyStimulus(2'b10, 2'b10, '0, '0, 513'd10, 513'd3);
    waitGrant("t2", 2'b10);
    checkOutput("t2 sub issue", addBus.add_subtract, 1);
    req = 2'b00;
    waitResp("t2", 1'b1);
    checkOutput("t2 valid", rspValid, 2'b10);
    checkOutput("t2 result", rspResult, 7);
    checkOutput("t2 sub resp", addBus.add_subtract, 0);

    // Test 3: both held, alternating grants starting with requester 0
    expSeq = '{2'b01, 2'b10, 2'b01, 2'b10};
    applyStimulus(2'b11, 2'b00, 513'd100, 513'd1, 513'd200, 513'd2);
    for (int t = 0; t < 4; t++) begin
      waitGrant($sformatf("t3.%0d", t), expSeq[t]);
      waitResp($sformatf("t3.%0d", t), 1'b0);
      checkOutput($sformatf("t3.%0d valid", t), rspValid, expSeq[t]);
      checkOutput($sformatf("t3.%0d result", t), rspResult, (t % 2 == 0) ? 101 : 202);
      if (t == 3) req = 2'b00;
    end
    @(negedge clk);
    checkOutput("t3 idle", busy, 0);

    // Test 4: adder never finishes -> watchdog after MAX_WAIT wait cycles
    stubMode = 1'b1;
    applyStimulus(2'b01, 2'b00, 513'd1, 513'd2, 513'd40, 513'd2);
    waitGrant("t4", 2'b01);
    req = 2'b00;
    busyCnt   = 0;
    errEarly  = 1'b0;
    validSeen = 1'b0;
    for (int n = 0; n < MAX_WAIT; n++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (timeoutErr) errEarly = 1'b1;
      if (rspValid != 2'b00) validSeen = 1'b1;
    end
    @(negedge clk);
    checkOutput("t4 wait cycles", busyCnt, MAX_WAIT);
    checkOutput("t4 err early", errEarly, 0);
    checkOutput("t4 busy after", busy, 0);
    checkOutput("t4 err set", timeoutErr, 1);
    checkOutput("t4 no resp", validSeen | (rspValid != 2'b00), 0);
    stubMode = 1'b0;
    req = 2'b10;
    waitGrant("t4b", 2'b10);
    req = 2'b00;
    waitResp("t4b", 1'b0);
    checkOutput("t4b valid", rspValid, 2'b10);
    checkOutput("t4b result", rspResult, 42);
    checkOutput("t4b err sticky", timeoutErr, 1);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    checkOutput("t4 err cleared", timeoutErr, 0);

    // Test 5: reset in the middle of WAIT
    stubMode = 1'b1;
    applyStimulus(2'b01, 2'b00, 513'd7, 513'd7, 513'd9, 513'd9);
    waitGrant("t5", 2'b01);
    req = 2'b00;
    repeat (2) @(negedge clk);
    checkOutput("t5 in wait", busy, 1);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("t5 busy", busy, 0);
    checkOutput("t5 start", addBus.add_start, 0);
    checkOutput("t5 in_a", addBus.add_in_a, 0);
    checkOutput("t5 result", rspResult, 0);
    checkOutput("t5 grant", grant, 0);
    resetn = 1'b1;
    stubMode = 1'b0;
    req = 2'b11;
    waitGrant("t5b", 2'b01);
    req = 2'b00;
    waitResp("t5b", 1'b0);
    checkOutput("t5b valid", rspValid, 2'b01);
    checkOutput("t5b result", rspResult, 14);

    // Test 6: full-width operands carry into bit 513
    allOnes = '1;
    expSum  = '1;
    expSum  = expSum - 514'd1;
    applyStimulus(2'b01, 2'b00, allOnes, allOnes, '0, '0);
    waitGrant("t6", 2'b01);
    req = 2'b00;
    waitResp("t6", 1'b0);
    checkOutput("t6 valid", rspValid, 2'b01);
    checkOutput("t6 result", rspResult, expSum);
    checkOutput("t6 bit513", rspResult[513], 1);
    checkOutput("t6 passthrough", rspResult, addBus.add_result);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
